// File: rtl/cmp_threshold_monitor.sv
// Debounced threshold alarm driven by the equal/greater/less flags of an upstream comparator.
// Optional build macro CMP_MONITOR_STICKY_EN: alarm latches in ACTIVE until clear or enable=0.
module cmp_threshold_monitor #(
    parameter int ASSERT_CNT  = 4,
    parameter int RELEASE_CNT = 2,
    parameter int EVT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             greater,
    input  logic             less,
    input  logic             equal,
    input  logic             mode,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [EVT_W-1:0] event_count,
    output logic             flag_error
);

    localparam int MAX_CNT = (ASSERT_CNT > RELEASE_CNT) ? ASSERT_CNT : RELEASE_CNT;
    localparam int RUN_W   = $clog2(MAX_CNT + 1);
    localparam logic [RUN_W-1:0] ASSERT_LAST = RUN_W'(ASSERT_CNT - 1);
`ifndef CMP_MONITOR_STICKY_EN
    localparam logic [RUN_W-1:0] RELEASE_LAST = RUN_W'(RELEASE_CNT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic [EVT_W-1:0]   event_q, event_d;
    logic               flag_q, flag_d;
    logic               mode_q;

    logic               flags_onehot;
    logic               good_sample;
    logic               bad_sample;
    logic               qual;
    logic               mode_changed;
    logic               assert_evt;
    logic [EVT_W-1:0]   event_base;

    // Exactly one of three: odd parity rules out 0 and 2 set, the AND rules out all three.
    assign flags_onehot = (greater ^ less ^ equal) & ~(greater & less & equal);
    assign good_sample  = sample_valid & flags_onehot;
    assign bad_sample   = sample_valid & ~flags_onehot;
    assign qual         = mode ? less : greater;
    assign mode_changed = (mode != mode_q);

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        alarm_d    = alarm_q;
        assert_evt = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            run_d   = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                    run_d   = '0;
                    alarm_d = 1'b0;
                end
                S_ARMED: begin
                    if (mode_changed) begin
                        run_d = '0;
                    end else if (good_sample) begin
                        if (qual) begin
                            if (run_q == ASSERT_LAST) begin
                                state_d    = S_ACTIVE;
                                run_d      = '0;
                                alarm_d    = 1'b1;
                                assert_evt = 1'b1;
                            end else begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end
                S_ACTIVE: begin
`ifdef CMP_MONITOR_STICKY_EN
                    run_d = '0;
                    if (clear) begin
                        state_d = S_ARMED;
                        alarm_d = 1'b0;
                    end
`else
                    if (mode_changed) begin
                        run_d = '0;
                    end else if (good_sample) begin
                        if (!qual) begin
                            if (run_q == RELEASE_LAST) begin
                                state_d = S_ARMED;
                                run_d   = '0;
                                alarm_d = 1'b0;
                            end else begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = '0;
                    alarm_d = 1'b0;
                end
            endcase
        end

        rise_d = alarm_d & ~alarm_q;
        fall_d = alarm_q & ~alarm_d;

        // clear acts first so a same-cycle assertion leaves the count at 1.
        event_base = clear ? '0 : event_q;
        if (assert_evt && (event_base != {EVT_W{1'b1}})) begin
            event_d = event_base + 1'b1;
        end else begin
            event_d = event_base;
        end

        flag_d = (clear ? 1'b0 : flag_q) | bad_sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            event_q <= '0;
            flag_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
            flag_q  <= flag_d;
            mode_q  <= mode;
        end
    end

    assign alarm       = alarm_q;
    assign alarm_rise  = rise_q;
    assign alarm_fall  = fall_q;
    assign event_count = event_q;
    assign flag_error  = flag_q;

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Directed bench for cmp_threshold_monitor; covers the sticky build when CMP_MONITOR_STICKY_EN is defined.
module tb_cmp_threshold_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sample_valid;
    logic       greater;
    logic       less;
    logic       equal;
    logic       mode;
    logic       clear;
    logic       alarm;
    logic       alarm_rise;
    logic       alarm_fall;
    logic [7:0] event_count;
    logic       flag_error;

    int n_tests = 0;
    int n_fail  = 0;

    cmp_threshold_monitor #(
        .ASSERT_CNT (4),
        .RELEASE_CNT(2),
        .EVT_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_valid(sample_valid),
        .greater     (greater),
        .less        (less),
        .equal       (equal),
        .mode        (mode),
        .clear       (clear),
        .alarm       (alarm),
        .alarm_rise  (alarm_rise),
        .alarm_fall  (alarm_fall),
        .event_count (event_count),
        .flag_error  (flag_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle carrying a valid sample with the given flags.
    task automatic smp(input logic g, input logic l, input logic e);
        sample_valid = 1'b1;
        greater = g;
        less    = l;
        equal   = e;
        tick();
        sample_valid = 1'b0;
        greater = 1'b0;
        less    = 1'b0;
        equal   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alarm"}, {31'd0, alarm}, 32'd0);
        check({tag, ".rise"},  {31'd0, alarm_rise}, 32'd0);
        check({tag, ".fall"},  {31'd0, alarm_fall}, 32'd0);
        check({tag, ".evt"},   {24'd0, event_count}, 32'd0);
        check({tag, ".ferr"},  {31'd0, flag_error}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        greater = 1'b0; less = 1'b0; equal = 1'b0; mode = 1'b0; clear = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        smp(1, 0, 0);                       // IDLE cycle: ignored
`ifndef CMP_MONITOR_STICKY_EN
        // 1: four greater -> alarm with rise after the 4th
        smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        check("t1.alarm_after3", {31'd0, alarm}, 32'd0);
        smp(1, 0, 0);
        check("t1.alarm", {31'd0, alarm}, 32'd1);
        check("t1.rise",  {31'd0, alarm_rise}, 32'd1);
        check("t1.evt",   {24'd0, event_count}, 32'd1);
        tick();
        check("t1.rise_one_cycle", {31'd0, alarm_rise}, 32'd0);
        check("t1.alarm_hold", {31'd0, alarm}, 32'd1);

        // 3: release by two less; interrupted run keeps alarm
        smp(0, 1, 0);
        check("t3.alarm_after1", {31'd0, alarm}, 32'd1);
        smp(0, 1, 0);
        check("t3.alarm_drop", {31'd0, alarm}, 32'd0);
        check("t3.fall", {31'd0, alarm_fall}, 32'd1);
        check("t3.rise_not_fall", {31'd0, alarm_rise}, 32'd0);
        tick();
        check("t3.fall_one_cycle", {31'd0, alarm_fall}, 32'd0);
        for (int i = 0; i < 4; i++) smp(1, 0, 0);
        check("t3.reassert_evt", {24'd0, event_count}, 32'd2);
        smp(0, 1, 0); smp(1, 0, 0); smp(0, 1, 0);
        check("t3.alarm_kept", {31'd0, alarm}, 32'd1);
        smp(1, 0, 0);                       // run back to 0

        // 2: equal breaks the run, invalid gaps do not
        smp(0, 1, 0); smp(0, 1, 0);
        check("t2.armed", {31'd0, alarm}, 32'd0);
        smp(1, 0, 0); tick(); smp(1, 0, 0); smp(1, 0, 0);
        smp(0, 0, 1);
        smp(1, 0, 0); tick(); tick(); smp(1, 0, 0); smp(1, 0, 0);
        check("t2.alarm_after7", {31'd0, alarm}, 32'd0);
        tick();
        smp(1, 0, 0);
        check("t2.alarm_after8", {31'd0, alarm}, 32'd1);
        check("t2.evt", {24'd0, event_count}, 32'd3);

        // 4: bad sample holds the run and sets the sticky error
        smp(0, 1, 0); smp(0, 1, 0);
        smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        smp(1, 1, 0);
        check("t4.flag", {31'd0, flag_error}, 32'd1);
        check("t4.no_alarm", {31'd0, alarm}, 32'd0);
        smp(1, 0, 0);
        check("t4.run_held_alarm", {31'd0, alarm}, 32'd1);
        check("t4.evt", {24'd0, event_count}, 32'd4);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t4.flag_cleared", {31'd0, flag_error}, 32'd0);
        check("t4.evt_cleared", {24'd0, event_count}, 32'd0);
        check("t4.alarm_unaffected", {31'd0, alarm}, 32'd1);

        // mode change: sample ignored in the change cycle, then qual flips to less
        mode = 1'b1;
        smp(1, 0, 0);
        smp(1, 0, 0);
        check("mode.alarm_held", {31'd0, alarm}, 32'd1);
        smp(1, 0, 0);
        check("mode.released", {31'd0, alarm}, 32'd0);
        check("mode.fall", {31'd0, alarm_fall}, 32'd1);
        mode = 1'b0;
        tick();

        // 5: saturation, clear with same-cycle assertion, disable while ACTIVE
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) smp(1, 0, 0);
            smp(0, 1, 0); smp(0, 1, 0);
        end
        check("t5.saturate", {24'd0, event_count}, 32'd255);
        smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        clear = 1'b1;
        smp(1, 0, 0);
        clear = 1'b0;
        check("t5.clear_plus_assert", {24'd0, event_count}, 32'd1);
        check("t5.active", {31'd0, alarm}, 32'd1);
        enable = 1'b0;
        tick();
        check("t5.disable_drop", {31'd0, alarm}, 32'd0);
        check("t5.disable_fall", {31'd0, alarm_fall}, 32'd1);
        tick();
        check("t5.fall_gone", {31'd0, alarm_fall}, 32'd0);
        enable = 1'b1;
        smp(1, 0, 0);                       // IDLE cycle: ignored
        smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        check("t5.idle_ignored", {31'd0, alarm}, 32'd0);
        smp(1, 0, 0);
        check("t5.rearm", {31'd0, alarm}, 32'd1);
        check("t5.evt2", {24'd0, event_count}, 32'd2);
`else
        // 6: sticky alarm ignores release runs, clear releases it
        for (int i = 0; i < 4; i++) smp(1, 0, 0);
        check("t6.alarm", {31'd0, alarm}, 32'd1);
        check("t6.evt", {24'd0, event_count}, 32'd1);
        for (int i = 0; i < 10; i++) smp(0, 1, 0);
        check("t6.sticky_hold", {31'd0, alarm}, 32'd1);
        check("t6.no_fall", {31'd0, alarm_fall}, 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t6.clear_drop", {31'd0, alarm}, 32'd0);
        check("t6.clear_fall", {31'd0, alarm_fall}, 32'd1);
        check("t6.evt_cleared", {24'd0, event_count}, 32'd0);
        smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        clear = 1'b1;
        smp(1, 0, 0);
        clear = 1'b0;
        check("t6.clear_assert", {31'd0, alarm}, 32'd1);
        check("t6.clear_assert_evt", {24'd0, event_count}, 32'd1);
        smp(1, 1, 0);
        check("t6.flag", {31'd0, flag_error}, 32'd1);
`endif
        // async reset mid-run: outputs drop before any clock edge
        smp(1, 1, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        check_all_zero("rst_held");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
